// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encoding and forward-select codes for hazard_ctrl
package hazard_ctrl_pkg;

    // Sequencer states: RUN normal flow, MEM_WAIT pipe frozen on data memory
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // E-stage operand source select
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Wait counter width (saturates at all ones)
    localparam int WAIT_W = 8;

    // True when a writing stage targets the given source register (x0 excluded)
    function automatic logic reg_match(input logic       wr_en,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return wr_en && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - one-operand bypass selector, M stage beats W stage
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // Youngest producer wins: M holds newer data than W for the same register
    always_comb begin
        fwd = FWD_RF;
        if (reg_match(reg_write_m, rd_m, rs_e)) begin
            fwd = FWD_MEM;
        end else if (reg_match(reg_write_w, rd_w, rs_e)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush/forward sequencer; optional perf counters under HAZARD_PERF_EN
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [4:0]       Rd_M,
    input  logic [4:0]       Rd_W,
    input  logic             ResultSrc_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             PCSrc_E,
    input  logic             mem_busy_M,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             hz_state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};

    hz_state_t         state;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              lwstall;

    fwd_sel u_fwd_a (
        .rs_e        (Rs1_E),
        .rd_m        (Rd_M),
        .reg_write_m (RegWrite_M),
        .rd_w        (Rd_W),
        .reg_write_w (RegWrite_W),
        .fwd         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs_e        (Rs2_E),
        .rd_m        (Rd_M),
        .reg_write_m (RegWrite_M),
        .rd_w        (Rd_W),
        .reg_write_w (RegWrite_W),
        .fwd         (fwd_b)
    );

    // Load in E whose result the D instruction needs cannot be bypassed in time
    assign lwstall = ResultSrc_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    assign hz_state = (state == ST_MEM_WAIT);

    // Next state and pipeline controls; memory busy freezes everything, else branch, else load-use
    always_comb begin
        state_next = state;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        ForwardA_E = fwd_a;
        ForwardB_E = fwd_b;
        if (rst) begin
            FlushD     = 1'b1;
            FlushE     = 1'b1;
            FlushW     = 1'b1;
            ForwardA_E = FWD_RF;
            ForwardB_E = FWD_RF;
            state_next = ST_RUN;
        end else if (mem_busy_M) begin
            // Same freeze in RUN and MEM_WAIT; E is held so branch/load-use wait for exit
            StallF     = 1'b1;
            StallD     = 1'b1;
            StallE     = 1'b1;
            StallM     = 1'b1;
            FlushW     = 1'b1;
            state_next = ST_MEM_WAIT;
        end else begin
            // Exit cycle of MEM_WAIT behaves exactly like RUN
            state_next = ST_RUN;
            if (PCSrc_E) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lwstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // State register, memory wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (!mem_busy_M) begin
                wait_cnt <= '0;
            end else if (state == ST_RUN) begin
                wait_cnt <= WAIT_W'(1);
            end else begin
                if (wait_cnt != WAIT_SAT) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt == WAIT_LIMIT) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running wrap-around counts of front-end stall and E-bubble cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (StallF) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (FlushE) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl (WAIT_MAX=4)
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic        ResultSrc_E, RegWrite_M, RegWrite_W, PCSrc_E, mem_busy_M;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        hz_state, timeout_err;
    logic [31:0] stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.WAIT_MAX(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .ResultSrc_E(ResultSrc_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .PCSrc_E(PCSrc_E), .mem_busy_M(mem_busy_M),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .hz_state(hz_state), .timeout_err(timeout_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed control word {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [6:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    // Advance to just after the next rising edge, where inputs are changed
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Outputs are sampled on the falling edge, mid-cycle
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
        Rd_E = 0; Rd_M = 0; Rd_W = 0;
        ResultSrc_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        PCSrc_E = 0; mem_busy_M = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Forward candidates present during reset must be masked
        Rs1_E = 5; Rd_M = 5; RegWrite_M = 1;
        settle();
        chk("rst_ctl", 32'(ctl()), 32'(7'b0000111));
        chk("rst_fwdA", 32'(ForwardA_E), 32'(2'b00));
        next_cycle();
        settle();
        chk("rst_state", 32'(hz_state), 32'(0));
        chk("rst_timeout", 32'(timeout_err), 32'(0));
        chk("rst_stall_cnt", stall_cycles, 32'(0));

        // Forwarding
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; Rd_W = 5; RegWrite_W = 1;
        settle();
        chk("fwdA_mem_beats_wb", 32'(ForwardA_E), 32'(2'b10));
        chk("fwdB_none", 32'(ForwardB_E), 32'(2'b00));
        chk("fwd_idle_ctl", 32'(ctl()), 32'(7'b0000000));
        next_cycle();
        Rd_M = 0; Rs2_E = 5;
        settle();
        chk("fwdA_rdm_x0_falls_to_wb", 32'(ForwardA_E), 32'(2'b01));
        chk("fwdB_wb", 32'(ForwardB_E), 32'(2'b01));
        next_cycle();
        Rd_M = 5; RegWrite_M = 0;
        settle();
        chk("fwdA_m_no_write", 32'(ForwardA_E), 32'(2'b01));
        next_cycle();
        RegWrite_M = 1; Rs1_E = 0; Rd_M = 0; Rd_W = 0;
        settle();
        chk("fwdA_x0_never", 32'(ForwardA_E), 32'(2'b00));
        next_cycle();
        Rs2_E = 9; Rd_M = 9; Rd_W = 3;
        settle();
        chk("fwdB_mem", 32'(ForwardB_E), 32'(2'b10));

        // Load-use: one bubble
        next_cycle();
        clear_inputs();
        ResultSrc_E = 1; Rd_E = 7; Rs2_D = 7;
        settle();
        chk("lwstall_ctl", 32'(ctl()), 32'(7'b1100010));
        next_cycle();
        ResultSrc_E = 0;
        settle();
        chk("lwstall_one_cycle", 32'(ctl()), 32'(7'b0000000));
        next_cycle();
        ResultSrc_E = 1; Rd_E = 0; Rs1_D = 0;
        settle();
        chk("lwstall_x0_none", 32'(ctl()), 32'(7'b0000000));

        // Branch beats load-use
        next_cycle();
        Rd_E = 7; Rs1_D = 7; PCSrc_E = 1;
        settle();
        chk("branch_over_lw", 32'(ctl()), 32'(7'b0000110));

        // Memory wait 3 cycles with redirect pending
        next_cycle();
        clear_inputs();
        mem_busy_M = 1; PCSrc_E = 1;
        settle();
        chk("mw1_ctl", 32'(ctl()), 32'(7'b1111001));
        chk("mw1_state", 32'(hz_state), 32'(0));
        for (int i = 2; i <= 3; i++) begin
            next_cycle();
            settle();
            chk($sformatf("mw%0d_ctl", i), 32'(ctl()), 32'(7'b1111001));
            chk($sformatf("mw%0d_state", i), 32'(hz_state), 32'(1));
        end
        next_cycle();
        mem_busy_M = 0;
        settle();
        chk("mw_exit_ctl", 32'(ctl()), 32'(7'b0000110));
        chk("mw_exit_state", 32'(hz_state), 32'(1));
        next_cycle();
        PCSrc_E = 0;
        settle();
        chk("mw_back_run", 32'(hz_state), 32'(0));

        // Timeout: WAIT_MAX=4 busy 6 cycles
        for (int i = 1; i <= 6; i++) begin
            next_cycle();
            mem_busy_M = 1;
            settle();
            chk($sformatf("to_busy%0d", i), 32'(timeout_err), 32'(i >= 6 ? 1 : 0));
        end
        next_cycle();
        mem_busy_M = 0;
        settle();
        chk("to_sticky_exit", 32'(timeout_err), 32'(1));
        next_cycle();
        settle();
        chk("to_sticky_run", 32'(timeout_err), 32'(1));
        chk("to_run_ctl", 32'(ctl()), 32'(7'b0000000));
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        settle();
        chk("to_cleared", 32'(timeout_err), 32'(0));

        // Reset during MEM_WAIT drops pending redirect
        next_cycle();
        mem_busy_M = 1; PCSrc_E = 1;
        next_cycle();
        settle();
        chk("rmw_state_wait", 32'(hz_state), 32'(1));
        next_cycle();
        rst = 1;
        settle();
        chk("rmw_rst_ctl", 32'(ctl()), 32'(7'b0000111));
        next_cycle();
        rst = 0; mem_busy_M = 0; PCSrc_E = 0;
        settle();
        chk("rmw_state_run", 32'(hz_state), 32'(0));
        chk("rmw_ctl", 32'(ctl()), 32'(7'b0000000));
        chk("rmw_stall_cnt", stall_cycles, 32'(0));
        chk("rmw_flush_cnt", flush_count, 32'(0));

`ifdef HAZARD_PERF_EN
        // One load-use cycle: one StallF, one FlushE
        next_cycle();
        ResultSrc_E = 1; Rd_E = 4; Rs1_D = 4;
        next_cycle();
        ResultSrc_E = 0;
        settle();
        chk("perf_stall_cnt", stall_cycles, 32'(1));
        chk("perf_flush_cnt", flush_count, 32'(1));
`else
        next_cycle();
        ResultSrc_E = 1; Rd_E = 4; Rs1_D = 4;
        next_cycle();
        ResultSrc_E = 0;
        settle();
        chk("perf_off_stall_cnt", stall_cycles, 32'(0));
        chk("perf_off_flush_cnt", flush_count, 32'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
